pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid.sv | 118 +++++++++++
 tb/tb_pipe_stage_skid.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Control bits are zeroed in every bubble; flush squashes held and incoming entries.
module pipe_stage_skid #(
    parameter int              DATA_W     = 32,
    parameter int              CTRL_W     = 4,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] w_main_ctrl_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic [CTRL_W-1:0] w_skid_ctrl_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic              w_push;
    logic              w_pop;

    // Handshake flags depend only on the registered occupancy, never on out_ready.
    assign in_ready  = (r_state != FULL);
    assign out_valid = (r_state != EMPTY);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign out_ctrl  = r_main_ctrl;
    assign out_data  = r_main_data;
    assign count     = r_state;

    always_comb begin
        w_state_nxt     = r_state;
        w_main_ctrl_nxt = r_main_ctrl;
        w_main_data_nxt = r_main_data;
        w_skid_ctrl_nxt = r_skid_ctrl;
        w_skid_data_nxt = r_skid_data;

        if (flush) begin
            // Squash everything; the head data stays visible but is no longer valid.
            w_state_nxt     = EMPTY;
            w_main_ctrl_nxt = '0;
            w_skid_ctrl_nxt = '0;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        w_main_ctrl_nxt = in_ctrl;
                        w_main_data_nxt = in_data;
                        w_state_nxt     = ONE;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        w_main_ctrl_nxt = in_ctrl;
                        w_main_data_nxt = in_data;
                    end else if (w_push) begin
                        w_skid_ctrl_nxt = in_ctrl;
                        w_skid_data_nxt = in_data;
                        w_state_nxt     = FULL;
                    end else if (w_pop) begin
                        w_main_ctrl_nxt = '0;
                        w_state_nxt     = EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        w_main_ctrl_nxt = r_skid_ctrl;
                        w_main_data_nxt = r_skid_data;
                        w_skid_ctrl_nxt = '0;
                        w_state_nxt     = ONE;
                    end
                end
                default: begin
                    w_state_nxt     = EMPTY;
                    w_main_ctrl_nxt = '0;
                    w_skid_ctrl_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state     <= EMPTY;
            r_main_ctrl <= '0;
            r_main_data <= RESET_DATA;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_main_ctrl <= w_main_ctrl_nxt;
            r_main_data <= w_main_data_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
            r_skid_data <= w_skid_data_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: queue-based reference model plus directed literal checks.
module tb_pipe_stage_skid;

    localparam int              DATA_W = 32;
    localparam int              CTRL_W = 4;
    localparam logic [DATA_W-1:0] RST_D = 32'hDEAD_0000;

    logic              clk = 1'b0;
    logic              clrn;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        count;

    int n_pass = 0;
    int n_total = 0;

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RESET_DATA(RST_D)) dut (
        .clk(clk), .clrn(clrn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: a FIFO of at most two entries plus the last head data seen.
    logic [CTRL_W-1:0] q_ctrl[$];
    logic [DATA_W-1:0] q_data[$];
    logic [DATA_W-1:0] m_hold;
    bit                m_init = 1'b0;

    always @(posedge clk) begin
        bit m_push, m_pop;
        if (!clrn) begin
            q_ctrl.delete();
            q_data.delete();
            m_hold = RST_D;
            m_init = 1'b1;
        end else if (m_init) begin
            m_push = in_valid && (q_data.size() < 2);
            m_pop  = out_ready && (q_data.size() > 0);
            if (flush) begin
                if (q_data.size() > 0) m_hold = q_data[0];
                q_ctrl.delete();
                q_data.delete();
            end else begin
                if (m_pop) begin
                    void'(q_ctrl.pop_front());
                    void'(q_data.pop_front());
                end
                if (m_push) begin
                    q_ctrl.push_back(in_ctrl);
                    q_data.push_back(in_data);
                end
                if (q_data.size() > 0) m_hold = q_data[0];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            int sz;
            sz = q_data.size();
            check("model_count", 64'(count), 64'(sz));
            check("model_out_valid", 64'(out_valid), 64'(sz != 0));
            check("model_in_ready", 64'(in_ready), 64'(sz != 2));
            check("model_out_ctrl", 64'(out_ctrl), (sz != 0) ? 64'(q_ctrl[0]) : 64'd0);
            check("model_out_data", 64'(out_data), (sz != 0) ? 64'(q_data[0]) : 64'(m_hold));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        clrn = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, '0);
        step(); step();
        clrn = 1'b1;
        check("reset_count", 64'(count), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_data", 64'(out_data), 64'(RST_D));

        // Reset mid-stream with a full buffer
        drive(1'b1, 4'hF, 32'h11); step();
        drive(1'b1, 4'hF, 32'h22); step();
        drive(1'b0, '0, '0);
        check("fill_count", 64'(count), 64'd2);
        check("fill_in_ready", 64'(in_ready), 64'd0);
        clrn = 1'b0; step(); clrn = 1'b1;
        check("rst_mid_count", 64'(count), 64'd0);
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_mid_data", 64'(out_data), 64'(RST_D));
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 4'h3, 32'(i));
            step();
            check("stream_data", 64'(out_data), 64'(i));
            check("stream_count", 64'(count), 64'd1);
        end
        drive(1'b0, '0, '0);
        step();
        check("stream_drained", 64'(out_valid), 64'd0);

        // Back-pressure into the skid register
        out_ready = 1'b0;
        drive(1'b1, 4'h5, 32'hAAAA0001); step();
        drive(1'b1, 4'h6, 32'hBBBB0002); step();
        drive(1'b0, '0, '0);
        check("bp_count", 64'(count), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_head_a", 64'(out_data), 64'h0000_0000_AAAA_0001);
        step();
        check("bp_stable", 64'(out_data), 64'h0000_0000_AAAA_0001);
        out_ready = 1'b1;
        step();
        check("bp_head_b", 64'(out_data), 64'h0000_0000_BBBB_0002);
        check("bp_in_ready_after", 64'(in_ready), 64'd1);
        check("bp_ctrl_b", 64'(out_ctrl), 64'h6);
        step();
        check("bp_empty", 64'(count), 64'd0);

        // Flush while full, with a simultaneous push that must be discarded
        out_ready = 1'b0;
        drive(1'b1, 4'h7, 32'h0000_00A1); step();
        drive(1'b1, 4'h7, 32'h0000_00B1); step();
        flush = 1'b1;
        drive(1'b1, 4'h9, 32'h0000_000C); step();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ctrl", 64'(out_ctrl), 64'd0);
        check("flush_data_kept", 64'(out_data), 64'h0000_00A1);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step(); step();
        check("flush_no_c", 64'(out_valid), 64'd0);

        // Push and pop together at count=1, then bubble after drain
        out_ready = 1'b0;
        drive(1'b1, 4'hF, 32'h0000_000D); step();
        check("pp_head_d", 64'(out_data), 64'h0000_000D);
        out_ready = 1'b1;
        drive(1'b1, 4'hF, 32'h0000_000E); step();
        drive(1'b0, '0, '0);
        check("pp_head_e", 64'(out_data), 64'h0000_000E);
        check("pp_count", 64'(count), 64'd1);
        step();
        check("bubble_valid", 64'(out_valid), 64'd0);
        check("bubble_ctrl", 64'(out_ctrl), 64'd0);
        check("bubble_data", 64'(out_data), 64'h0000_000E);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
